nbin_bit_serializer: RTL and testbench



---
 rtl/nbin_bit_serializer_if.sv | 29 ++
 rtl/nbin_bit_serializer.sv | 132 +++++++++++++
 tb/tb_nbin_bit_serializer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nbin_bit_serializer_if.sv
// Brick handshake and serial-output bundle between NBin, the serializer and the NFU array.
// master = upstream/consumer side; slave = the serializer itself.
interface nbin_bit_serializer_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned Ti = 16,
  parameter int unsigned Tw = 16
) ();

  logic                  i_valid;
  logic                  o_ready;
  logic [Tw*Ti*N-1:0]    i_neurons;
  logic [4:0]            i_precision;
  logic [Tw*Ti-1:0]      o_neurons;
  logic                  o_valid;
  logic                  o_first_cycle;
  logic                  o_last_cycle;
  logic                  o_busy;

  modport master (
    output i_valid, i_neurons, i_precision,
    input  o_ready, o_neurons, o_valid, o_first_cycle, o_last_cycle, o_busy
  );

  modport slave (
    input  i_valid, i_neurons, i_precision,
    output o_ready, o_neurons, o_valid, o_first_cycle, o_last_cycle, o_busy
  );

endinterface

// File: rtl/nbin_bit_serializer.sv
// Double-buffered brick serializer: emits Tw*Ti neurons bit-serially, sign bit first,
// over a per-brick precision of p cycles with first/last-cycle markers.
module nbin_bit_serializer #(
  parameter int unsigned N  = 16,
  parameter int unsigned Ti = 16,
  parameter int unsigned Tw = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  nbin_bit_serializer_if.slave  bus
);

  localparam int unsigned NumNeurons = Tw * Ti;
  localparam int unsigned BrickW     = NumNeurons * N;
  localparam int unsigned PW         = $clog2(N + 1);
  localparam int unsigned CW         = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StSerial} state_e;

  state_e                state_q, state_d;
  logic [BrickW-1:0]     act_brick_q, act_brick_d;
  logic [PW-1:0]         act_prec_q, act_prec_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic [BrickW-1:0]     pend_brick_q, pend_brick_d;
  logic [PW-1:0]         pend_prec_q, pend_prec_d;
  logic                  pend_valid_q, pend_valid_d;

  logic [NumNeurons-1:0] neurons_q, neurons_d;
  logic                  valid_q, valid_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;

  logic                  accept;
  logic                  load_point;
  logic [PW-1:0]         in_prec;
  logic [N-1:0]          word;

  assign bus.o_ready = ~pend_valid_q & ~reset;
  assign accept      = bus.i_valid & bus.o_ready;

  // Out-of-range precisions fall back to full width.
  assign in_prec = (bus.i_precision == 5'd0 || 32'(bus.i_precision) > N) ?
                   PW'(N) : PW'(bus.i_precision);

  // A new brick may start when idle or when the current one is on its LSB.
  assign load_point = (state_q == StIdle) || (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    act_brick_d  = act_brick_q;
    act_prec_d   = act_prec_q;
    cnt_d        = cnt_q;
    pend_brick_d = pend_brick_q;
    pend_prec_d  = pend_prec_q;
    pend_valid_d = pend_valid_q;

    if (load_point) begin
      if (pend_valid_q) begin
        act_brick_d  = pend_brick_q;
        act_prec_d   = pend_prec_q;
        cnt_d        = pend_prec_q - PW'(1);
        pend_valid_d = 1'b0;
        state_d      = StSerial;
      end else if (accept) begin
        act_brick_d = bus.i_neurons;
        act_prec_d  = in_prec;
        cnt_d       = in_prec - PW'(1);
        state_d     = StSerial;
      end else begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    end else begin
      cnt_d = cnt_q - PW'(1);
      if (accept) begin
        pend_brick_d = bus.i_neurons;
        pend_prec_d  = in_prec;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Outputs are computed from next state so bit k shows right after the edge setting cnt=k.
  always_comb begin
    neurons_d = '0;
    word      = '0;
    valid_d   = (state_d == StSerial);
    first_d   = valid_d && (cnt_d == act_prec_d - PW'(1));
    last_d    = valid_d && (cnt_d == '0);
    if (valid_d) begin
      for (int j = 0; j < int'(NumNeurons); j++) begin
        word         = act_brick_d[j*N +: N];
        neurons_d[j] = word[cnt_d[CW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      act_brick_q  <= '0;
      act_prec_q   <= '0;
      cnt_q        <= '0;
      pend_brick_q <= '0;
      pend_prec_q  <= '0;
      pend_valid_q <= 1'b0;
      neurons_q    <= '0;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_brick_q  <= act_brick_d;
      act_prec_q   <= act_prec_d;
      cnt_q        <= cnt_d;
      pend_brick_q <= pend_brick_d;
      pend_prec_q  <= pend_prec_d;
      pend_valid_q <= pend_valid_d;
      neurons_q    <= neurons_d;
      valid_q      <= valid_d;
      first_q      <= first_d;
      last_q       <= last_d;
    end
  end

  assign bus.o_neurons     = neurons_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_first_cycle = first_q;
  assign bus.o_last_cycle  = last_q;
  assign bus.o_busy        = (state_q == StSerial) | pend_valid_q;

endmodule

// File: tb/tb_nbin_bit_serializer.sv
// Bench for nbin_bit_serializer: queue-based stream model checked every cycle,
// plus directed bricks with literal expectations and a randomized phase.
module tb_nbin_bit_serializer;

  localparam int NN = 256;
  localparam int BW = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  nbin_bit_serializer_if #(.N(16), .Ti(16), .Tw(16)) bus ();

  nbin_bit_serializer #(.N(16), .Ti(16), .Tw(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NN-1:0] bits;
    logic          first;
    logic          last;
  } ent_t;

  typedef struct {
    logic b0;
    logic b255;
    logic first;
    logic last;
    int   cyc;
  } cap_t;

  ent_t q[$];    // expected serial stream, one entry per valid cycle
  cap_t cap[$];  // observed valid cycles, for directed literal checks
  int   held = 0;
  bit   acc_flag = 1'b0;

  task automatic chk(input string name, input logic [NN-1:0] act, input logic [NN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_brick(input logic [BW-1:0] br, input logic [4:0] p);
    int   pe;
    ent_t e;
    pe = (p == 0 || p > 16) ? 16 : int'(p);
    for (int k = pe - 1; k >= 0; k--) begin
      for (int j = 0; j < NN; j++) e.bits[j] = br[16*j + k];
      e.first = (k == pe - 1);
      e.last  = (k == 0);
      q.push_back(e);
    end
    held++;
  endtask

  always @(negedge clk) begin : monitor
    logic rdy_e;
    ent_t e;
    if (reset) begin
      chk("reset_valid", bus.o_valid, 0);
      chk("reset_neurons", bus.o_neurons, '0);
      chk("reset_first", bus.o_first_cycle, 0);
      chk("reset_last", bus.o_last_cycle, 0);
      chk("reset_busy", bus.o_busy, 0);
      chk("reset_ready", bus.o_ready, 0);
      q.delete();
      held = 0;
      acc_flag = 1'b0;
    end else begin
      rdy_e = (held < 2);
      chk("ready", bus.o_ready, rdy_e);
      chk("busy", bus.o_busy, held > 0);
      chk("valid", bus.o_valid, q.size() > 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (bus.o_valid) begin
          chk("neurons", bus.o_neurons, e.bits);
          chk("first", bus.o_first_cycle, e.first);
          chk("last", bus.o_last_cycle, e.last);
        end
        if (e.last) held--;
      end else if (!bus.o_valid) begin
        chk("idle_neurons", bus.o_neurons, '0);
        chk("idle_flags", {bus.o_first_cycle, bus.o_last_cycle}, 0);
      end
      if (bus.o_valid)
        cap.push_back('{bus.o_neurons[0], bus.o_neurons[255], bus.o_first_cycle,
                        bus.o_last_cycle, cyc});
      acc_flag = bus.i_valid && rdy_e;
      if (acc_flag) push_brick(bus.i_neurons, bus.i_precision);
    end
  end

  function automatic logic [63:0] pack(input int sel, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = v << 1;
      if (i < cap.size()) begin
        case (sel)
          0:       v[0] = cap[i].b0;
          1:       v[0] = cap[i].b255;
          2:       v[0] = cap[i].first;
          default: v[0] = cap[i].last;
        endcase
      end
    end
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_brick();
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Present one brick and hold it until the handshake; returns at posedge+1.
  task automatic send(input logic [BW-1:0] br, input logic [4:0] p);
    bit ok;
    ok = 1'b0;
    bus.i_valid     = 1'b1;
    bus.i_neurons   = br;
    bus.i_precision = p;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (acc_flag) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_accept: got no handshake expected one within 100 cycles");
    end
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && held == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idle: got model still busy expected drain within 300 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    logic [BW-1:0] br;
    bus.i_valid     = 1'b0;
    bus.i_neurons   = '0;
    bus.i_precision = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single brick, neuron (0,0)=5, p=4.
    cap.delete();
    br = '0;
    br[15:0] = 16'h0005;
    send(br, 5'd4);
    wait_idle();
    chk("t1_len", cap.size(), 4);
    chk("t1_bits", pack(0, 4), 4'b0101);
    chk("t1_first", pack(2, 4), 4'b1000);
    chk("t1_last", pack(3, 4), 4'b0001);
    chk("t1_busy", bus.o_busy, 0);

    // Neuron (15,15)=-3 with p=4; upper bits ignored.
    cap.delete();
    br = '0;
    br[BW-1 -: 16] = 16'hFFFD;
    send(br, 5'd4);
    wait_idle();
    chk("t2_bits", pack(1, 4), 4'b1101);

    // p=3 then p=5 back to back: 8 contiguous cycles.
    cap.delete();
    send(rand_brick(), 5'd3);
    send(rand_brick(), 5'd5);
    wait_idle();
    chk("t3_len", cap.size(), 8);
    chk("t3_first", pack(2, 8), 8'b1001_0000);
    chk("t3_last", pack(3, 8), 8'b0010_0001);
    if (cap.size() == 8) chk("t3_contig", cap[7].cyc - cap[0].cyc, 7);

    // Three full-precision bricks: 48 contiguous cycles.
    cap.delete();
    send(rand_brick(), 5'd16);
    send(rand_brick(), 5'd16);
    send(rand_brick(), 5'd16);
    wait_idle();
    chk("t4_len", cap.size(), 48);
    chk("t4_first", pack(2, 48), 48'h8000_8000_8000);
    chk("t4_last", pack(3, 48), 48'h0001_0001_0001);
    if (cap.size() == 48) chk("t4_contig", cap[47].cyc - cap[0].cyc, 47);

    // Precision sanitising and the p=1 corner.
    cap.delete();
    br = '0;
    br[15:0] = 16'hA5C3;
    send(br, 5'd0);
    wait_idle();
    chk("t5_p0_len", cap.size(), 16);
    chk("t5_p0_bits", pack(0, 16), 16'hA5C3);
    cap.delete();
    br[15:0] = 16'h8001;
    send(br, 5'd20);
    wait_idle();
    chk("t5_p20_len", cap.size(), 16);
    chk("t5_p20_bits", pack(0, 16), 16'h8001);
    cap.delete();
    br[15:0] = 16'h0003;
    send(br, 5'd1);
    wait_idle();
    chk("t5_p1_len", cap.size(), 1);
    chk("t5_p1_bits", pack(0, 1), 1'b1);
    chk("t5_p1_flags", {pack(2, 1), pack(3, 1)}, {64'd1, 64'd1});

    // Reset in cycle 3 of a p=8 brick with a pending brick held.
    send(rand_brick(), 5'd8);
    send(rand_brick(), 5'd8);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", bus.o_valid, 0);
    chk("t6_async_neurons", bus.o_neurons, '0);
    chk("t6_async_flags", {bus.o_first_cycle, bus.o_last_cycle}, 0);
    chk("t6_async_busy", bus.o_busy, 0);
    chk("t6_async_ready", bus.o_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cap.delete();
    #1;
    chk("t6_post_ready", bus.o_ready, 1);
    chk("t6_post_busy", bus.o_busy, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_stale", cap.size(), 0);

    // Randomized bricks, precisions and gaps.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(rand_brick(), 5'($urandom_range(0, 31)));
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
